conv_host_mem: RTL and testbench
================================

Name: conv_host_mem

Overview:
- Host-side responder for the CONV accelerator's three memory buses: image memory (iaddr/idata), layer-memory write (cwr/caddr_wr/cdata_wr/csel) and layer-memory read (crd/caddr_rd/cdata_rd/csel).
- Also owns the ready/busy start handshake, a run-cycle counter and watchdog, and a backpressured dump port that streams any layer memory out after the run completes.
- Sits between the system host (image load, start, result readout) and the accelerator core.

Parameters:
- DW, 20, data width (Q4.16 words)
- AW, 12, address width on all buses
- IMG_DEPTH, 4096, image words (64x64)
- L0_DEPTH, 4096, words per layer-0 bank (csel 1, 2)
- L1_DEPTH, 1024, words per layer-1 bank (csel 3, 4)
- L2_DEPTH, 2048, words in flatten bank (csel 5)
- TIMEOUT, 32'd2000000, maximum RUN cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ready  out  1  start request to core
- busy  in  1  core busy
- iaddr  in  AW  image read address
- idata  out  DW  image read data
- cwr  in  1  layer write strobe
- caddr_wr  in  AW  layer write address
- cdata_wr  in  DW  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  AW  layer read address
- cdata_rd  out  DW  layer read data
- csel  in  3  bank select: 1=L0k0, 2=L0k1, 3=L1k0, 4=L1k1, 5=L2; 0/6/7=none
- ld_valid  in  1  host image write strobe
- ld_addr  in  AW  host image address
- ld_data  in  DW  host image data
- start  in  1  one-cycle start pulse
- dump_req  in  1  one-cycle dump request
- dump_sel  in  3  bank to dump, same encoding as csel
- dump_valid  out  1  dump word valid
- dump_ready  in  1  dump sink ready
- dump_addr  out  AW  address of current dump word
- dump_data  out  DW  dump word
- done  out  1  one-cycle pulse on run completion
- timeout  out  1  sticky watchdog abort flag
- err_oob  out  1  sticky out-of-range access flag
- run_cycles  out  32  cycles spent in RUN

Behaviour:
- Reset values: ready=0, dump_valid=0, dump_addr=0, done=0, timeout=0, err_oob=0, run_cycles=0, state=IDLE. Memory contents are not reset.
- Reads are combinational with zero latency:
  - idata = img[iaddr], in every state.
  - cdata_rd = bank[csel][caddr_rd] when crd=1 and csel is 1..5 and the address is in range; otherwise 0.
- Writes occur at the posedge:
  - cwr=1 with csel 1..5 and caddr_wr < bank depth writes cdata_wr to that bank.
  - csel 0/6/7 with cwr=1: no write, no error.
- Out-of-range access: an address >= bank depth on an enabled read or write sets err_oob (sticky until reset). A write is dropped; a read returns 0.
- Same-cycle write and read of the same bank/address: cdata_rd returns the old contents; the new value is visible the next cycle.
- Image load: ld_valid=1 writes img[ld_addr] in IDLE only; ignored in other states. Out-of-range ld_addr sets err_oob.
- States:
  - IDLE: start=1 -> READY, clearing run_cycles and timeout. dump_req=1 -> DUMP (dump_addr=0). start has priority over dump_req.
  - READY: ready=1; busy=1 sampled -> RUN with ready=0 the next cycle.
  - RUN: run_cycles increments every cycle. busy=0 sampled -> IDLE with done=1 for one cycle. run_cycles==TIMEOUT-1 -> IDLE with timeout=1 and no done pulse.
  - DUMP:
    - dump_valid=1, dump_data=bank[dump_sel][dump_addr].
    - Transfer occurs when dump_valid and dump_ready. On transfer, dump_addr increments; on the last word (depth-1) -> IDLE with dump_valid=0, dump_addr=0.
    - dump_addr/dump_data stay stable while dump_ready=0.
    - dump_sel is latched on entry; invalid dump_sel returns to IDLE immediately with no dump_valid.
- start and dump_req outside IDLE are ignored. Async reset mid-run or mid-dump returns to IDLE immediately; memories keep their contents.

Test Plan:
- Reset asserted mid-DUMP -> next cycle all outputs at reset values, state IDLE; bank 3 word 10 still readable.
- In IDLE, ld_valid with ld_addr=5, ld_data=20'h12345, then iaddr=5 -> idata=20'h12345 in the same cycle as iaddr. ld_valid during RUN with ld_addr=5, data 0 -> idata remains 20'h12345.
- Bank writes and reads:
  - cwr=1, csel=3, caddr_wr=10, cdata_wr=20'hABCDE; next cycle crd=1, csel=3, caddr_rd=10 -> cdata_rd=20'hABCDE.
  - Write csel=4 addr 10 = 20'h00011 -> csel=4 read returns 20'h00011 and csel=3 still returns 20'hABCDE.
  - crd=0 -> cdata_rd=0.
- cwr=1, csel=3, caddr_wr=1024 -> no write, err_oob=1 and held. cwr=1 with csel=0 -> err_oob unchanged from a fresh reset.
- Start handshake:
  - start pulse -> ready=1 next cycle.
  - busy raised 3 cycles later -> ready=0 the following cycle.
  - busy held 500 cycles then dropped -> done pulses once, run_cycles=500, timeout=0.
  - With TIMEOUT=100 and busy stuck high -> timeout=1 after 100 RUN cycles, no done pulse.
- Dump: fill bank 5 with data=address; dump_req with dump_sel=5 and dump_ready toggling 1,0,1,0 -> 2048 transfers, addresses 0..2047 in order, data==address, values stable during stalls, then dump_valid=0. dump_sel=7 -> no dump_valid, back to IDLE.

Source files
------------

// File: rtl/conv_host_mem.sv
// Host-side memory responder for the CONV accelerator: image and layer banks,
// start handshake with run watchdog, and a backpressured layer-memory dump port.
module conv_host_mem #(
  parameter int unsigned DW        = 20,
  parameter int unsigned AW        = 12,
  parameter int unsigned IMG_DEPTH = 4096,
  parameter int unsigned L0_DEPTH  = 4096,
  parameter int unsigned L1_DEPTH  = 1024,
  parameter int unsigned L2_DEPTH  = 2048,
  parameter logic [31:0] TIMEOUT   = 32'd2000000
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic          dump_req,
  input  logic [2:0]    dump_sel,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          timeout,
  output logic          err_oob,
  output logic [31:0]   run_cycles
);

  localparam int IMG_IW = $clog2(IMG_DEPTH);
  localparam int L0_IW  = $clog2(L0_DEPTH);
  localparam int L1_IW  = $clog2(L1_DEPTH);
  localparam int L2_IW  = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {IDLE, READY, RUN, DUMP} state_t;
  state_t state;

  logic [DW-1:0] img  [IMG_DEPTH];
  logic [DW-1:0] l0k0 [L0_DEPTH];
  logic [DW-1:0] l0k1 [L0_DEPTH];
  logic [DW-1:0] l1k0 [L1_DEPTH];
  logic [DW-1:0] l1k1 [L1_DEPTH];
  logic [DW-1:0] l2   [L2_DEPTH];

  logic [2:0]  dump_sel_q;
  logic [31:0] sel_depth;
  logic [31:0] dump_depth;
  logic        rd_en, rd_hit, wr_en, wr_hit, ld_en, ld_hit, oob_hit, dump_last;

  // A depth of zero marks an unmapped select code (0, 6, 7).
  function automatic logic [31:0] bank_depth(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: bank_depth = L0_DEPTH;
      3'd3, 3'd4: bank_depth = L1_DEPTH;
      3'd5:       bank_depth = L2_DEPTH;
      default:    bank_depth = '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a, input logic [31:0] depth);
    in_range = 32'(a) < depth;
  endfunction

  function automatic logic [DW-1:0] bank_read(input logic [2:0] sel, input logic [AW-1:0] a);
    case (sel)
      3'd1:    bank_read = l0k0[a[L0_IW-1:0]];
      3'd2:    bank_read = l0k1[a[L0_IW-1:0]];
      3'd3:    bank_read = l1k0[a[L1_IW-1:0]];
      3'd4:    bank_read = l1k1[a[L1_IW-1:0]];
      3'd5:    bank_read = l2[a[L2_IW-1:0]];
      default: bank_read = '0;
    endcase
  endfunction

  // Zero-latency read paths and range checks for every enabled access.
  always_comb begin
    sel_depth  = bank_depth(csel);
    dump_depth = bank_depth(dump_sel_q);
    rd_en      = crd && (sel_depth != '0);
    rd_hit     = rd_en && in_range(caddr_rd, sel_depth);
    wr_en      = cwr && (sel_depth != '0);
    wr_hit     = wr_en && in_range(caddr_wr, sel_depth);
    ld_en      = ld_valid && (state == IDLE);
    ld_hit     = ld_en && in_range(ld_addr, IMG_DEPTH);
    oob_hit    = (rd_en && !rd_hit) || (wr_en && !wr_hit) || (ld_en && !ld_hit);
    cdata_rd   = rd_hit ? bank_read(csel, caddr_rd) : '0;
    idata      = in_range(iaddr, IMG_DEPTH) ? img[iaddr[IMG_IW-1:0]] : '0;
    dump_data  = dump_valid ? bank_read(dump_sel_q, dump_addr) : '0;
    dump_last  = (32'(dump_addr) == (dump_depth - 32'd1));
  end

  // Memory arrays are deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (ld_hit) img[ld_addr[IMG_IW-1:0]] <= ld_data;
    if (wr_hit) begin
      case (csel)
        3'd1:    l0k0[caddr_wr[L0_IW-1:0]] <= cdata_wr;
        3'd2:    l0k1[caddr_wr[L0_IW-1:0]] <= cdata_wr;
        3'd3:    l1k0[caddr_wr[L1_IW-1:0]] <= cdata_wr;
        3'd4:    l1k1[caddr_wr[L1_IW-1:0]] <= cdata_wr;
        3'd5:    l2[caddr_wr[L2_IW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_sel_q <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err_oob    <= 1'b0;
      run_cycles <= '0;
    end else begin
      done <= 1'b0;
      if (oob_hit) err_oob <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READY;
            ready      <= 1'b1;
            run_cycles <= '0;
            timeout    <= 1'b0;
          end else if (dump_req) begin
            dump_sel_q <= dump_sel;
            dump_addr  <= '0;
            if (bank_depth(dump_sel) != '0) begin
              state      <= DUMP;
              dump_valid <= 1'b1;
            end
          end
        end
        READY: begin
          if (busy) begin
            state <= RUN;
            ready <= 1'b0;
          end
        end
        // The exit cycle is counted too, so run_cycles equals cycles spent in RUN.
        RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (!busy) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (run_cycles == TIMEOUT - 32'd1) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              dump_addr  <= '0;
            end else begin
              dump_addr <= dump_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_host_mem.sv
// Randomized and directed bench for conv_host_mem against an array-based
// model of the image/layer memories and the handshake/dump rules.
module tb_conv_host_mem;

  localparam int          DW         = 20;
  localparam int          AW         = 12;
  localparam logic [31:0] TB_TIMEOUT = 32'd600;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready, busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr, crd;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr, cdata_rd;
  logic [2:0]    csel;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          start, dump_req;
  logic [2:0]    dump_sel;
  logic          dump_valid, dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          done, timeout, err_oob;
  logic [31:0]   run_cycles;

  conv_host_mem #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .dump_req(dump_req), .dump_sel(dump_sel),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done), .timeout(timeout), .err_oob(err_oob), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mbank [8][4096];
  logic [DW-1:0] mimg  [4096];
  logic          exp_err;

  function automatic int depth_of(input int sel);
    case (sel)
      1, 2:    return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] sel, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    cwr = w; csel = sel; caddr_wr = wa; cdata_wr = wd; crd = r; caddr_rd = ra;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_dump_valid"}, dump_valid, 0);
    checkOutput({tag, "_dump_addr"}, dump_addr, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_err_oob"}, err_oob, 0);
    checkOutput({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dn, k, exp_a, dep;
    logic rdy_t;
    logic [DW-1:0] d;
    logic [AW-1:0] wa, ra, ia;
    logic w, r;
    logic [2:0] sel;

    reset = 1'b1; busy = 0; iaddr = '0; ld_valid = 0; ld_addr = '0; ld_data = '0;
    start = 0; dump_req = 0; dump_sel = '0; dump_ready = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 checkResetState("reset");

    // Preload every bank and the image with random data so all reads are defined.
    for (int s = 1; s <= 5; s++) begin
      for (int a = 0; a < depth_of(s); a++) begin
        d = DW'($urandom);
        applyStimulus(1, 3'(s), AW'(a), d, 0, 0);
        tick;
        mbank[s][a] = d;
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    ld_valid = 1;
    for (int a = 0; a < 4096; a++) begin
      d = DW'($urandom);
      ld_addr = AW'(a); ld_data = d;
      tick;
      mimg[a] = d;
    end
    ld_valid = 0;

    applyStimulus(1, 0, 10, 20'h55555, 1, 10);
    #1 checkOutput("csel0_rd", cdata_rd, 0);
    tick;
    checkOutput("csel0_err", err_oob, 0);

    ld_valid = 1; ld_addr = 5; ld_data = 20'h12345;
    tick;
    mimg[5] = 20'h12345;
    ld_valid = 0; iaddr = 5;
    #1 checkOutput("img_ld", idata, 20'h12345);

    applyStimulus(1, 3, 10, 20'hABCDE, 0, 0);
    tick; mbank[3][10] = 20'hABCDE;
    applyStimulus(0, 3, 0, 0, 1, 10);
    #1 checkOutput("b3_rd", cdata_rd, 20'hABCDE);
    applyStimulus(1, 4, 10, 20'h00011, 0, 0);
    tick; mbank[4][10] = 20'h00011;
    applyStimulus(0, 4, 0, 0, 1, 10);
    #1 checkOutput("b4_rd", cdata_rd, 20'h00011);
    applyStimulus(0, 3, 0, 0, 1, 10);
    #1 checkOutput("b3_rd_again", cdata_rd, 20'hABCDE);
    applyStimulus(0, 3, 0, 0, 0, 10);
    #1 checkOutput("crd0", cdata_rd, 0);
    applyStimulus(1, 3, 10, 20'h13579, 1, 10);
    #1 checkOutput("rw_same_old", cdata_rd, 20'hABCDE);
    tick; mbank[3][10] = 20'h13579;
    applyStimulus(0, 3, 0, 0, 1, 10);
    #1 checkOutput("rw_same_new", cdata_rd, 20'h13579);

    applyStimulus(1, 3, 12'd1024, 20'hFFFFF, 0, 0);
    tick;
    checkOutput("oob_wr_err", err_oob, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) tick;
    checkOutput("oob_err_held", err_oob, 1);
    applyStimulus(0, 3, 0, 0, 1, 0);
    #1 checkOutput("oob_no_alias", cdata_rd, 32'(mbank[3][0]));
    applyStimulus(0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1 checkResetState("reset2");

    // Random bank/image traffic: reads see pre-edge contents, writes land at the edge.
    exp_err = 0;
    for (int it = 0; it < 400; it++) begin
      w = 1'($urandom); r = 1'($urandom); sel = 3'($urandom_range(0, 7));
      dep = depth_of(int'(sel));
      wa = (dep != 0 && $urandom_range(0, 1) == 1) ? AW'($urandom_range(0, dep - 1)) : AW'($urandom);
      ra = (dep != 0 && $urandom_range(0, 1) == 1) ? AW'($urandom_range(0, dep - 1)) : AW'($urandom);
      d = DW'($urandom); ia = AW'($urandom);
      applyStimulus(w, sel, wa, d, r, ra);
      iaddr = ia;
      ld_valid = ($urandom_range(0, 3) == 0); ld_addr = AW'($urandom); ld_data = DW'($urandom);
      #1;
      checkOutput("rand_rd", cdata_rd, (r && dep != 0 && int'(ra) < dep) ? 32'(mbank[sel][ra]) : 0);
      checkOutput("rand_idata", idata, 32'(mimg[ia]));
      if (dep != 0 && ((r && int'(ra) >= dep) || (w && int'(wa) >= dep))) exp_err = 1;
      @(posedge clk); #1;
      if (w && dep != 0 && int'(wa) < dep) mbank[sel][wa] = d;
      if (ld_valid) mimg[ld_addr] = ld_data;
      checkOutput("rand_err", err_oob, 32'(exp_err));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    ld_valid = 0;

    start = 1; tick; start = 0;
    checkOutput("hs_ready", ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("hs_ready_hold", ready, 1);
    end
    busy = 1; tick;
    checkOutput("hs_ready_drop", ready, 0);
    dn = 0;
    for (int i = 1; i < 500; i++) begin
      if (i == 100) begin
        ld_valid = 1; ld_addr = 5; ld_data = 0; start = 1; dump_req = 1; dump_sel = 5;
      end
      tick;
      ld_valid = 0; start = 0; dump_req = 0;
      if (done) dn++;
    end
    iaddr = 5;
    #1 checkOutput("run_ld_ignored", idata, 32'(mimg[5]));
    checkOutput("run_dump_ignored", dump_valid, 0);
    checkOutput("run_no_early_done", dn, 0);
    busy = 0; tick;
    checkOutput("run_done", done, 1);
    checkOutput("run_cycles", run_cycles, 500);
    checkOutput("run_timeout", timeout, 0);
    tick;
    checkOutput("run_done_pulse", done, 0);

    start = 1; tick; start = 0;
    checkOutput("to_ready", ready, 1);
    checkOutput("to_cleared", run_cycles, 0);
    busy = 1; tick;
    k = 0; dn = 0;
    while (timeout !== 1'b1 && k < 800) begin
      tick; k++;
      if (done) dn++;
    end
    checkOutput("to_cycles_waited", k, 600);
    checkOutput("to_flag", timeout, 1);
    checkOutput("to_no_done", dn, 0);
    checkOutput("to_run_cycles", run_cycles, 600);
    busy = 0; repeat (3) tick;
    checkOutput("to_sticky", timeout, 1);
    start = 1; tick; start = 0;
    checkOutput("restart_ready", ready, 1);
    checkOutput("restart_to_clear", timeout, 0);
    busy = 1; tick; busy = 0; tick;
    checkOutput("short_done", done, 1);
    checkOutput("short_cycles", run_cycles, 1);

    for (int a = 0; a < 2048; a++) begin
      applyStimulus(1, 5, AW'(a), DW'(a), 0, 0);
      tick;
      mbank[5][a] = DW'(a);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    dump_sel = 5; dump_req = 1; tick; dump_req = 0;
    exp_a = 0; rdy_t = 1;
    for (int c = 0; c < 6000 && exp_a < 2048; c++) begin
      dump_ready = rdy_t;
      #1;
      checkOutput("dump_valid", dump_valid, 1);
      checkOutput("dump_addr", dump_addr, exp_a);
      checkOutput("dump_data", dump_data, 32'(mbank[5][exp_a]));
      if (rdy_t) exp_a++;
      rdy_t = ~rdy_t;
      @(posedge clk); #1;
    end
    dump_ready = 0;
    checkOutput("dump_count", exp_a, 2048);
    checkOutput("dump_end_valid", dump_valid, 0);
    checkOutput("dump_end_addr", dump_addr, 0);

    dump_sel = 7; dump_req = 1; tick; dump_req = 0;
    checkOutput("dump7_valid", dump_valid, 0);
    tick;
    checkOutput("dump7_valid_hold", dump_valid, 0);
    start = 1; tick; start = 0;
    checkOutput("dump7_idle", ready, 1);
    busy = 1; tick; busy = 0; tick;
    checkOutput("dump7_done", done, 1);

    dump_sel = 3; dump_req = 1; dump_ready = 1; tick; dump_req = 0;
    repeat (5) tick;
    checkOutput("mid_dump_addr", dump_addr, 5);
    #2 reset = 1'b1;
    #1 checkResetState("mid_dump_async");
    tick;
    reset = 1'b0; dump_ready = 0;
    #1 checkResetState("mid_dump_after");
    tick;
    checkOutput("mid_dump_idle", dump_valid, 0);
    applyStimulus(0, 3, 0, 0, 1, 10);
    #1 checkOutput("mid_dump_mem", cdata_rd, 32'(mbank[3][10]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
